// File: rtl/memory_stage.sv
// Memory stage: single-outstanding load/store to data memory; MEM_MISALIGN_TRAP_EN turns misaligned H/W into a trap with no bus access.
// Latency: non-memory ops 0 cycles; loads release the cycle after dmem_rvalid; fast stores the cycle after command accept.
// Backpressure: mem_stall_flg holds upstream until the access completes; command outputs hold while dmem_cmd_ready is low.
package memory_stage_pkg;
    typedef enum logic [1:0] {MEN_X = 2'd0, MEN_S = 2'd1, MEN_L = 2'd2} mem_wen_t;
    typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} mem_size_t;
    typedef struct packed {
        mem_wen_t    mem_wen;
        mem_size_t   mem_size;
        logic        mem_sext;
        logic [31:0] rs2_data;
    } ctrltype;
endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned STORE_WAIT_ACK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_reg_pc,
    input  logic [31:0] mem_inst,
    input  logic [63:0] mem_inst_id,
    input  ctrltype     mem_ctrl,
    input  logic [31:0] mem_alu_out,
    output logic        dmem_cmd_start,
    output logic        dmem_cmd_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_cmd_ready,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic        mem_wb_valid,
    output logic [31:0] mem_wb_reg_pc,
    output logic [31:0] mem_wb_inst,
    output logic [63:0] mem_wb_inst_id,
    output ctrltype     mem_wb_ctrl,
    output logic [31:0] mem_wb_result,
    output logic        mem_misaligned,
    input  logic        pipeline_flush,
    output logic        mem_stall_flg
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic        done_flag_q, done_flag_d;
    logic [63:0] done_id_q, done_id_d;
    logic [31:0] saved_result_q, saved_result_d;

    logic        is_mem, is_load, is_store, misaligned, done_hit, cmd_accept, store_fast;
    logic [31:0] addr;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_mem   = mem_valid && (mem_ctrl.mem_wen != MEN_X);
    assign is_load  = is_mem && (mem_ctrl.mem_wen == MEN_L);
    assign is_store = is_mem && (mem_ctrl.mem_wen == MEN_S);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_mem && (((mem_ctrl.mem_size == SIZE_H) && mem_alu_out[0]) ||
                                   ((mem_ctrl.mem_size == SIZE_W) && (mem_alu_out[1:0] != 2'b00)));
    assign addr = mem_alu_out;
`else
    assign misaligned = 1'b0;
    // Silently align: halfwords drop bit 0, words drop bits 1:0
    always_comb begin
        addr = mem_alu_out;
        if (mem_ctrl.mem_size == SIZE_H) addr[0] = 1'b0;
        else if (mem_ctrl.mem_size == SIZE_W) addr[1:0] = 2'b00;
    end
`endif

    assign lane       = addr[1:0];
    assign done_hit   = done_flag_q && (done_id_q == mem_inst_id);
    assign store_fast = is_store && (STORE_WAIT_ACK == 0);

    assign dmem_cmd_start = (state_q == S_IDLE) && is_mem && !misaligned && !done_hit;
    assign cmd_accept     = dmem_cmd_start && dmem_cmd_ready;
    assign dmem_cmd_write = is_store;
    assign dmem_addr      = {addr[31:2], 2'b00};

    always_comb begin
        dmem_wdata = mem_ctrl.rs2_data;
        dmem_wmask = 4'b1111;
        case (mem_ctrl.mem_size)
            SIZE_B: begin
                dmem_wdata = {4{mem_ctrl.rs2_data[7:0]}};
                dmem_wmask = 4'b0001 << lane;
            end
            SIZE_H: begin
                dmem_wdata = {2{mem_ctrl.rs2_data[15:0]}};
                dmem_wmask = 4'b0011 << lane;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (mem_ctrl.mem_size)
            SIZE_B:  ld_data = {{24{mem_ctrl.mem_sext & ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_data = {{16{mem_ctrl.mem_sext & ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        done_flag_d    = done_flag_q;
        done_id_d      = done_id_q;
        saved_result_d = saved_result_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    // A command accepted under flush is still in flight unless nothing comes back
                    if (pipeline_flush) begin
                        state_d     = store_fast ? S_IDLE : S_DRAIN;
                        done_flag_d = 1'b0;
                    end else if (store_fast) begin
                        state_d     = S_DONE;
                        done_flag_d = 1'b1;
                        done_id_d   = mem_inst_id;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (pipeline_flush) begin
                    done_flag_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (pipeline_flush) begin
                    state_d     = dmem_rvalid ? S_IDLE : S_DRAIN;
                    done_flag_d = 1'b0;
                end else if (dmem_rvalid) begin
                    saved_result_d = ld_data;
                    done_id_d      = mem_inst_id;
                    done_flag_d    = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                if (pipeline_flush || !mem_valid || (mem_inst_id != done_id_q)) begin
                    done_flag_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dmem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            done_flag_q    <= 1'b0;
            done_id_q      <= 64'hffff000000000000;
            saved_result_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            done_flag_q    <= done_flag_d;
            done_id_q      <= done_id_d;
            saved_result_q <= saved_result_d;
        end
    end

    assign mem_stall_flg  = (is_mem && !misaligned && !done_hit) || (state_q == S_DRAIN);
    assign mem_wb_valid   = mem_valid && !mem_stall_flg && !pipeline_flush;
    assign mem_wb_reg_pc  = mem_reg_pc;
    assign mem_wb_inst    = mem_inst;
    assign mem_wb_inst_id = mem_inst_id;
    assign mem_wb_ctrl    = mem_ctrl;
    assign mem_wb_result  = misaligned ? 32'h0 : (is_load ? saved_result_q : mem_alu_out);
    assign mem_misaligned = misaligned;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, flush/drain, back-to-back ids, alignment handling.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_reg_pc, mem_inst, mem_alu_out;
    logic [63:0] mem_inst_id;
    ctrltype     mem_ctrl;
    logic        dmem_cmd_start, dmem_cmd_write, dmem_cmd_ready, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        mem_wb_valid, mem_misaligned, pipeline_flush, mem_stall_flg;
    logic [31:0] mem_wb_reg_pc, mem_wb_inst, mem_wb_result;
    logic [63:0] mem_wb_inst_id;
    ctrltype     mem_wb_ctrl;

    typedef struct {
        logic [63:0] id;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int a0;

    memory_stage #(.STORE_WAIT_ACK(0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_reg_pc(mem_reg_pc),
        .mem_inst(mem_inst), .mem_inst_id(mem_inst_id), .mem_ctrl(mem_ctrl),
        .mem_alu_out(mem_alu_out), .dmem_cmd_start(dmem_cmd_start),
        .dmem_cmd_write(dmem_cmd_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_cmd_ready(dmem_cmd_ready), .dmem_rdata(dmem_rdata),
        .dmem_rvalid(dmem_rvalid), .mem_wb_valid(mem_wb_valid), .mem_wb_reg_pc(mem_wb_reg_pc),
        .mem_wb_inst(mem_wb_inst), .mem_wb_inst_id(mem_wb_inst_id), .mem_wb_ctrl(mem_wb_ctrl),
        .mem_wb_result(mem_wb_result), .mem_misaligned(mem_misaligned),
        .pipeline_flush(pipeline_flush), .mem_stall_flg(mem_stall_flg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Writeback monitor: every released result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && mem_wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", mem_wb_inst_id, 64'hx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_id", mem_wb_inst_id, e.id);
                chk("wb_result", {32'h0, mem_wb_result}, {32'h0, e.res});
            end
        end
        if (rst_n && dmem_cmd_start && dmem_cmd_ready) n_acc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input mem_wen_t wen, input mem_size_t sz, input logic sext,
                            input logic [31:0] rs2, input logic [31:0] addr, input logic [63:0] id);
        mem_valid        = 1'b1;
        mem_ctrl.mem_wen  = wen;
        mem_ctrl.mem_size = sz;
        mem_ctrl.mem_sext = sext;
        mem_ctrl.rs2_data = rs2;
        mem_alu_out      = addr;
        mem_inst_id      = id;
        mem_reg_pc       = {id[29:0], 2'b00};
        mem_inst         = 32'h0000_0013;
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        mem_ctrl  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_wb_valid", mem_wb_valid, 0);
            chk("idle_stall", mem_stall_flg, 0);
            step();
        end
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [63:0] id,
                            input mem_size_t sz, input logic sext, input logic [31:0] rdata,
                            input int ready_wait, input int rsp_delay, input logic [31:0] exp_res,
                            input logic [3:0] exp_mask, input logic b2b);
        drive_op(MEN_L, sz, sext, 32'h0, addr, id);
        sb.push_back('{id, exp_res});
        dmem_cmd_ready = 1'b0;
        dmem_rvalid    = 1'b0;
        if (b2b) begin
            @(negedge clk);
            chk("ld_b2b_no_start", dmem_cmd_start, 0);
            chk("ld_b2b_stall", mem_stall_flg, 1);
            step();
        end
        for (int i = 0; i < ready_wait; i++) begin
            @(negedge clk);
            chk("ld_start_wait", dmem_cmd_start, 1);
            chk("ld_addr_wait", dmem_addr, exp_addr);
            step();
        end
        dmem_cmd_ready = 1'b1;
        @(negedge clk);
        chk("ld_start", dmem_cmd_start, 1);
        chk("ld_write", dmem_cmd_write, 0);
        chk("ld_addr", dmem_addr, exp_addr);
        chk("ld_mask", dmem_wmask, exp_mask);
        chk("ld_misaligned", mem_misaligned, 0);
        chk("ld_stall_acc", mem_stall_flg, 1);
        step();
        dmem_cmd_ready = 1'b0;
        for (int i = 1; i < rsp_delay; i++) begin
            @(negedge clk);
            chk("ld_wait_start", dmem_cmd_start, 0);
            chk("ld_wait_stall", mem_stall_flg, 1);
            step();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        chk("ld_rvalid_stall", mem_stall_flg, 1);
        chk("ld_rvalid_wb", mem_wb_valid, 0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        @(negedge clk);
        chk("ld_release_stall", mem_stall_flg, 0);
        chk("ld_release_wb", mem_wb_valid, 1);
        step();
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [63:0] id, input mem_size_t sz,
                             input logic [31:0] rs2, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_mask, input int ready_wait);
        drive_op(MEN_S, sz, 1'b0, rs2, addr, id);
        sb.push_back('{id, addr});
        dmem_cmd_ready = 1'b0;
        for (int i = 0; i <= ready_wait; i++) begin
            if (i == ready_wait) dmem_cmd_ready = 1'b1;
            @(negedge clk);
            chk("st_start", dmem_cmd_start, 1);
            chk("st_write", dmem_cmd_write, 1);
            chk("st_addr", dmem_addr, exp_addr);
            chk("st_wdata", dmem_wdata, exp_wdata);
            chk("st_mask", dmem_wmask, exp_mask);
            chk("st_stall", mem_stall_flg, 1);
            step();
        end
        dmem_cmd_ready = 1'b0;
        @(negedge clk);
        chk("st_release_stall", mem_stall_flg, 0);
        chk("st_release_start", dmem_cmd_start, 0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_reg_pc = '0; mem_inst = '0; mem_inst_id = '0;
        mem_ctrl = '0; mem_alu_out = '0; dmem_cmd_ready = 1'b0; dmem_rdata = '0;
        dmem_rvalid = 1'b0; pipeline_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_start", dmem_cmd_start, 0);
        chk("rst_wb_valid", mem_wb_valid, 0);
        chk("rst_misaligned", mem_misaligned, 0);
        chk("rst_stall", mem_stall_flg, 0);
        step();
        rst_n = 1'b1;
        idle(1);

        // Non-memory pass-through, then the same kind of op killed by flush
        drive_op(MEN_X, SIZE_W, 1'b0, 32'h0, 32'h55, 64'd2);
        sb.push_back('{64'd2, 32'h55});
        @(negedge clk);
        chk("pt_stall", mem_stall_flg, 0);
        chk("pt_start", dmem_cmd_start, 0);
        chk("pt_pc", mem_wb_reg_pc, 32'h8);
        step();
        drive_op(MEN_X, SIZE_W, 1'b0, 32'h0, 32'h66, 64'd3);
        pipeline_flush = 1'b1;
        @(negedge clk);
        chk("pt_flush_wb", mem_wb_valid, 0);
        step();
        pipeline_flush = 1'b0;
        idle(1);

        // LW: ready at once, data two cycles later
        a0 = n_acc;
        run_load(32'h100, 32'h100, 64'd1, SIZE_W, 1'b0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 4'hF, 1'b0);
        idle(1);
        chk("lw_one_cmd", n_acc, a0 + 1);
        run_load(32'h103, 32'h100, 64'd10, SIZE_B, 1'b1, 32'h80112233, 1, 1, 32'hFFFFFF80, 4'b1000, 1'b0);
        idle(1);
        run_load(32'h103, 32'h100, 64'd11, SIZE_B, 1'b0, 32'h80112233, 0, 3, 32'h00000080, 4'b1000, 1'b0);
        idle(1);
        run_load(32'h102, 32'h100, 64'd12, SIZE_H, 1'b1, 32'h80112233, 0, 1, 32'hFFFF8011, 4'b1100, 1'b0);
        idle(1);
        run_load(32'h100, 32'h100, 64'd13, SIZE_H, 1'b0, 32'h80119233, 0, 1, 32'h00009233, 4'b0011, 1'b0);
        idle(1);

        // Stores with delayed ready
        run_store(32'h202, 64'd14, SIZE_H, 32'h0000_1234, 32'h200, 32'h12341234, 4'b1100, 3);
        idle(1);
        run_store(32'h201, 64'd15, SIZE_B, 32'h0000_00AB, 32'h200, 32'hABABABAB, 4'b0010, 0);
        idle(1);
        run_store(32'h300, 64'd16, SIZE_W, 32'hCAFEF00D, 32'h300, 32'hCAFEF00D, 4'b1111, 1);
        idle(1);

        // Flush while waiting: drain the response and drop it
        a0 = n_acc;
        drive_op(MEN_L, SIZE_W, 1'b0, 32'h0, 32'h100, 64'd20);
        dmem_cmd_ready = 1'b1;
        @(negedge clk);
        chk("fl_start", dmem_cmd_start, 1);
        step();
        dmem_cmd_ready = 1'b0;
        @(negedge clk);
        chk("fl_wait_stall", mem_stall_flg, 1);
        step();
        pipeline_flush = 1'b1;
        @(negedge clk);
        chk("fl_pulse_wb", mem_wb_valid, 0);
        step();
        pipeline_flush = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("fl_drain_stall", mem_stall_flg, 1);
        chk("fl_drain_start", dmem_cmd_start, 0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        chk("fl_rvalid_stall", mem_stall_flg, 1);
        chk("fl_rvalid_wb", mem_wb_valid, 0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        @(negedge clk);
        chk("fl_after_stall", mem_stall_flg, 0);
        chk("fl_after_wb", mem_wb_valid, 0);
        step();
        chk("fl_one_cmd", n_acc, a0 + 1);
        run_load(32'h104, 32'h104, 64'd21, SIZE_W, 1'b0, 32'h01234567, 0, 1, 32'h01234567, 4'hF, 1'b0);

        // Back-to-back ids straight out of DONE
        a0 = n_acc;
        run_load(32'h108, 32'h108, 64'd30, SIZE_W, 1'b0, 32'h11111111, 1, 2, 32'h11111111, 4'hF, 1'b1);
        run_load(32'h10C, 32'h10C, 64'd31, SIZE_W, 1'b0, 32'h22222222, 0, 1, 32'h22222222, 4'hF, 1'b1);
        idle(1);
        chk("b2b_cmds", n_acc, a0 + 2);

        // Misaligned word access
`ifdef MEM_MISALIGN_TRAP_EN
        a0 = n_acc;
        drive_op(MEN_L, SIZE_W, 1'b0, 32'h0, 32'h101, 64'd40);
        sb.push_back('{64'd40, 32'h0});
        @(negedge clk);
        chk("mis_flag", mem_misaligned, 1);
        chk("mis_start", dmem_cmd_start, 0);
        chk("mis_stall", mem_stall_flg, 0);
        chk("mis_wb", mem_wb_valid, 1);
        step();
        idle(1);
        chk("mis_no_cmd", n_acc, a0);
`else
        run_load(32'h101, 32'h100, 64'd40, SIZE_W, 1'b0, 32'h11223344, 0, 1, 32'h11223344, 4'hF, 1'b0);
        idle(1);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
